crc_stream_gen: RTL and testbench
=================================

CRC_STREAM_GEN -- requirements
Module: crc_stream_gen

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 512: beat width in bits; multiple of 8, >= 16.
REQ-002 SHALL have parameter CRC_WIDTH, default 32: checksum width.
REQ-003 SHALL have parameter GEN_POLY, default 32'h814141AB: generator polynomial, implicit top "1" omitted.
REQ-004 SHALL have parameter INIT_VAL, default all-zero: CRC register seed at message start.
REQ-005 SHALL have parameter XOR_OUT, default all-zero: value XORed onto the final CRC.
REQ-006 SHALL have parameter CNT_WIDTH, default 16: beat counter width.
REQ-007 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-008 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-009 SHALL have port clear_i, input, 1: synchronous abort of the current message.
REQ-010 SHALL have port data_i, input, DATA_WIDTH: beat data, MSB processed first.
REQ-011 SHALL have port valid_i, input, 1: beat valid.
REQ-012 SHALL have port last_i, input, 1: beat is the final beat of its message.
REQ-013 SHALL have port last_bytes_i, input, $clog2(DATA_WIDTH/8): valid bytes on the last beat, MSB-aligned; 0 = all bytes valid.
REQ-014 SHALL have port ready_o, output, 1: beat accepted when valid_i && ready_o.
REQ-015 SHALL have port checksum_o, output, CRC_WIDTH: final checksum.
REQ-016 SHALL have port checksum_valid_o, output, 1: checksum_o holds a valid result.
REQ-017 SHALL have port checksum_ready_i, input, 1: consumer accepts the result.
REQ-018 SHALL have port beat_cnt_o, output, CNT_WIDTH: beats accepted in the current or most recent message.

Function
REQ-019 SHALL implement states ACCUM and DONE; ACCUM accepts beats, DONE holds the result.
REQ-020 Per-bit update SHALL be: if crc[MSB] != data bit, crc = (crc << 1) ^ GEN_POLY; else crc = crc << 1; bits taken MSB-first.
REQ-021 Each accepted beat SHALL apply all DATA_WIDTH bits in one cycle; when last_i=1 and last_bytes_i=N>0, only the top 8*N bits are applied and lower bytes are ignored.
REQ-022 The first beat of a message SHALL start from INIT_VAL; later beats continue from the stored CRC.
REQ-023 ready_o SHALL be 1 in ACCUM and 0 in DONE (no combinational dependence on valid_i).
REQ-024 On acceptance with last_i=1: next cycle state = DONE, checksum_valid_o = 1, checksum_o = updated CRC ^ XOR_OUT (latency 1 cycle).
REQ-025 In DONE, checksum_o and checksum_valid_o SHALL hold stable until checksum_valid_o && checksum_ready_i; the next cycle the state is ACCUM with the CRC reseeded to INIT_VAL.
REQ-026 Back-to-back messages SHALL lose one cycle at most: ready_o rises the cycle after the result handshake.
REQ-027 beat_cnt_o SHALL increment per accepted beat, saturate at all-ones, reset to 0 on the first beat of a new message (value 1), and hold in DONE.
REQ-028 clear_i=1 SHALL, next cycle, force ACCUM, reseed the CRC to INIT_VAL, clear beat_cnt_o, and drop checksum_valid_o; any beat presented that cycle is discarded; clear_i takes priority over every other event.
REQ-029 valid_i=0 cycles mid-message SHALL leave the CRC and counter unchanged.
REQ-030 Output checksum_o SHALL be registered; DONE-state values do not change with data_i.

Reset
REQ-031 While rst_n=0: state = ACCUM, CRC register = INIT_VAL, checksum_o = 0, checksum_valid_o = 0, beat_cnt_o = 0, ready_o = 1 after deassertion.
REQ-032 Reset asserted mid-message or in DONE SHALL discard the message and result without an output handshake.

Verification
REQ-033 DATA_WIDTH=32, defaults: one beat 32'h00000001, last_i=1 -> next cycle checksum_valid_o=1, checksum_o=32'h814141AB, beat_cnt_o=1.
REQ-034 DATA_WIDTH=32: last beat 32'h01ABCDEF, last_bytes_i=1 -> checksum_o=32'h814141AB (lower 3 bytes ignored).
REQ-035 INIT_VAL=0, XOR_OUT=32'hFFFFFFFF: three zero beats, last on third -> checksum_o=32'hFFFFFFFF, beat_cnt_o=3.
REQ-036 Random 2-beat messages at DATA_WIDTH=32 with random valid_i gaps -> checksum_o equals the bit-serial model over the 64 concatenated bits; ready_o=0 throughout DONE.
REQ-037 Hold checksum_ready_i=0 for 10 cycles in DONE -> checksum_o stable, no beats accepted; assert clear_i -> checksum_valid_o=0 and ready_o=1 next cycle.
REQ-038 Assert rst_n=0 mid-message after 2 beats -> all outputs at reset values; the next single-beat 32'h00000001 message -> 32'h814141AB.

Source files
------------

// File: rtl/crc_stream_gen.sv
// crc_stream_gen: streaming CRC over DATA_WIDTH-bit beats (MSB first), one full beat per cycle.
// Checksum is registered 1 cycle after the last beat; ready_o stays low until the result is consumed.
module crc_stream_gen #(
  parameter int                   DATA_WIDTH = 512,
  parameter int                   CRC_WIDTH  = 32,
  parameter logic [CRC_WIDTH-1:0] GEN_POLY   = CRC_WIDTH'(32'h814141AB),
  parameter logic [CRC_WIDTH-1:0] INIT_VAL   = '0,
  parameter logic [CRC_WIDTH-1:0] XOR_OUT    = '0,
  parameter int                   CNT_WIDTH  = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              clear_i,
  input  logic [DATA_WIDTH-1:0]             data_i,
  input  logic                              valid_i,
  input  logic                              last_i,
  input  logic [$clog2(DATA_WIDTH/8)-1:0]   last_bytes_i,
  output logic                              ready_o,
  output logic [CRC_WIDTH-1:0]              checksum_o,
  output logic                              checksum_valid_o,
  input  logic                              checksum_ready_i,
  output logic [CNT_WIDTH-1:0]              beat_cnt_o
);

  localparam int LB_W = $clog2(DATA_WIDTH/8);
  localparam int NB_W = LB_W + 4;

  typedef enum logic {ACCUM = 1'b0, DONE = 1'b1} state_t;

  state_t               state_q;
  logic [CRC_WIDTH-1:0] crc_q;
  logic [CRC_WIDTH-1:0] crc_nxt;
  logic [NB_W-1:0]      n_bits;
  logic                 msg_active_q;

  assign ready_o = (state_q == ACCUM);

  // Bits beyond n_bits belong to the unused low bytes of a short last beat.
  always_comb begin
    n_bits = NB_W'(DATA_WIDTH);
    if (last_i && (last_bytes_i != '0)) n_bits = {1'b0, last_bytes_i, 3'b000};
    crc_nxt = crc_q;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (NB_W'(i) < n_bits) begin
        if (crc_nxt[CRC_WIDTH-1] != data_i[DATA_WIDTH-1-i])
          crc_nxt = {crc_nxt[CRC_WIDTH-2:0], 1'b0} ^ GEN_POLY;
        else
          crc_nxt = {crc_nxt[CRC_WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ACCUM;
      crc_q            <= INIT_VAL;
      checksum_o       <= '0;
      checksum_valid_o <= 1'b0;
      beat_cnt_o       <= '0;
      msg_active_q     <= 1'b0;
    end else if (clear_i) begin
      state_q          <= ACCUM;
      crc_q            <= INIT_VAL;
      checksum_valid_o <= 1'b0;
      beat_cnt_o       <= '0;
      msg_active_q     <= 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (valid_i) begin
            if (!msg_active_q)
              beat_cnt_o <= CNT_WIDTH'(1);
            else if (!(&beat_cnt_o))
              beat_cnt_o <= beat_cnt_o + CNT_WIDTH'(1);
            if (last_i) begin
              state_q          <= DONE;
              checksum_o       <= crc_nxt ^ XOR_OUT;
              checksum_valid_o <= 1'b1;
              crc_q            <= INIT_VAL;
              msg_active_q     <= 1'b0;
            end else begin
              crc_q        <= crc_nxt;
              msg_active_q <= 1'b1;
            end
          end
        end
        DONE: begin
          if (checksum_ready_i) begin
            state_q          <= ACCUM;
            checksum_valid_o <= 1'b0;
          end
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_crc_stream_gen.sv
// Directed bench for crc_stream_gen at DATA_WIDTH=32; a second instance uses XOR_OUT=all-ones and a 2-bit counter.
module tb_crc_stream_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear_i = 1'b0;
  logic [31:0] data_i = '0;
  logic        valid_i = 1'b0;
  logic        last_i = 1'b0;
  logic [1:0]  last_bytes_i = '0;
  logic        checksum_ready_i = 1'b0;

  logic        ready_a, ready_b;
  logic [31:0] csum_a, csum_b;
  logic        cvld_a, cvld_b;
  logic [15:0] cnt_a;
  logic [1:0]  cnt_b;

  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  crc_stream_gen #(.DATA_WIDTH(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .clear_i(clear_i), .data_i(data_i),
    .valid_i(valid_i), .last_i(last_i), .last_bytes_i(last_bytes_i),
    .ready_o(ready_a), .checksum_o(csum_a), .checksum_valid_o(cvld_a),
    .checksum_ready_i(checksum_ready_i), .beat_cnt_o(cnt_a)
  );

  crc_stream_gen #(.DATA_WIDTH(32), .XOR_OUT(32'hFFFFFFFF), .CNT_WIDTH(2)) u_dut_x (
    .clk(clk), .rst_n(rst_n), .clear_i(clear_i), .data_i(data_i),
    .valid_i(valid_i), .last_i(last_i), .last_bytes_i(last_bytes_i),
    .ready_o(ready_b), .checksum_o(csum_b), .checksum_valid_o(cvld_b),
    .checksum_ready_i(checksum_ready_i), .beat_cnt_o(cnt_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [31:0] d, input logic l, input logic [1:0] lb);
    data_i = d; valid_i = 1'b1; last_i = l; last_bytes_i = lb;
    @(posedge clk); #1;
    valid_i = 1'b0; last_i = 1'b0; last_bytes_i = '0;
  endtask

  task automatic take();
    checksum_ready_i = 1'b1;
    @(posedge clk); #1;
    checksum_ready_i = 1'b0;
  endtask

  // Plain bit-serial reference: low n bits of 'bits', highest first.
  function automatic logic [31:0] crc_model(input logic [63:0] bits, input int n);
    logic [31:0] c;
    c = 32'h0;
    for (int i = n - 1; i >= 0; i--) begin
      if (c[31] != bits[i]) c = {c[30:0], 1'b0} ^ 32'h814141AB;
      else                  c = {c[30:0], 1'b0};
    end
    return c;
  endfunction

  initial begin
    logic [31:0] d0, d1, expc;

    // Reset values while held in reset
    repeat (2) @(posedge clk);
    #1;
    check("rst_csum", csum_a, 32'h0);
    check("rst_cvld", 32'(cvld_a), 32'h0);
    check("rst_cnt", 32'(cnt_a), 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_ready", 32'(ready_a), 32'h1);

    // Single beat 0x00000001
    beat(32'h00000001, 1'b1, 2'd0);
    check("one_cvld", 32'(cvld_a), 32'h1);
    check("one_csum", csum_a, 32'h814141AB);
    check("one_cnt", 32'(cnt_a), 32'h1);
    check("one_ready_done", 32'(ready_a), 32'h0);
    take();
    check("one_ready_after", 32'(ready_a), 32'h1);
    check("one_cvld_after", 32'(cvld_a), 32'h0);

    // Short last beat: only top byte 0x01 counts
    beat(32'h01ABCDEF, 1'b1, 2'd1);
    check("short_csum", csum_a, 32'h814141AB);
    take();

    // 0x00000002: POLY after bit 30, then one more shift with feedback
    beat(32'h00000002, 1'b1, 2'd0);
    check("two_csum", csum_a, 32'h83C3C2FD);
    take();

    // Three zero beats with idle gaps; XOR_OUT instance yields all-ones
    beat(32'h0, 1'b0, 2'd0);
    repeat (2) @(posedge clk);
    #1;
    check("zero_cnt_mid", 32'(cnt_a), 32'h1);
    beat(32'h0, 1'b0, 2'd0);
    @(posedge clk); #1;
    beat(32'h0, 1'b1, 2'd0);
    check("zero_csum_a", csum_a, 32'h0);
    check("zero_csum_x", csum_b, 32'hFFFFFFFF);
    check("zero_cnt", 32'(cnt_a), 32'h3);
    check("zero_cvld_x", 32'(cvld_b), 32'h1);

    // Stall in DONE with beats offered: nothing accepted, result stable
    data_i = 32'hDEADBEEF; valid_i = 1'b1; last_i = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      check("stall_csum_x", csum_b, 32'hFFFFFFFF);
      check("stall_ready", 32'(ready_a), 32'h0);
      check("stall_cnt", 32'(cnt_a), 32'h3);
    end
    valid_i = 1'b0; last_i = 1'b0;
    clear_i = 1'b1;
    @(posedge clk); #1;
    clear_i = 1'b0;
    check("clr_cvld", 32'(cvld_a), 32'h0);
    check("clr_ready", 32'(ready_a), 32'h1);
    check("clr_cnt", 32'(cnt_a), 32'h0);

    // Beat presented together with clear is dropped
    data_i = 32'hFFFFFFFF; valid_i = 1'b1; clear_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0; clear_i = 1'b0;
    beat(32'h00000001, 1'b1, 2'd0);
    check("clrbeat_csum", csum_a, 32'h814141AB);
    check("clrbeat_cnt", 32'(cnt_a), 32'h1);
    take();
    check("cnt_hold_after_take", 32'(cnt_a), 32'h1);

    // Five zero beats: wide counter reaches 5, 2-bit counter saturates at 3
    for (int k = 0; k < 5; k++) beat(32'h0, (k == 4), 2'd0);
    check("sat_cnt_a", 32'(cnt_a), 32'h5);
    check("sat_cnt_x", 32'(cnt_b), 32'h3);
    take();

    // Random two-beat messages with gaps, against the bit-serial model
    for (int m = 0; m < 4; m++) begin
      d0 = $urandom;
      d1 = $urandom;
      expc = crc_model({d0, d1}, 64);
      beat(d0, 1'b0, 2'd0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      beat(d1, 1'b1, 2'd0);
      check("rnd_csum", csum_a, expc);
      check("rnd_csum_x", csum_b, expc ^ 32'hFFFFFFFF);
      check("rnd_cnt", 32'(cnt_a), 32'h2);
      for (int w = 0; w < int'($urandom_range(1, 3)); w++) begin
        @(posedge clk); #1;
        check("rnd_ready_done", 32'(ready_a), 32'h0);
        check("rnd_csum_hold", csum_a, expc);
      end
      take();
    end

    // Async reset mid-message after two beats
    beat(32'h12345678, 1'b0, 2'd0);
    beat(32'h9ABCDEF0, 1'b0, 2'd0);
    check("pre_rst_cnt", 32'(cnt_a), 32'h2);
    #2 rst_n = 1'b0;
    #1;
    check("mrst_csum", csum_a, 32'h0);
    check("mrst_cvld", 32'(cvld_a), 32'h0);
    check("mrst_cnt", 32'(cnt_a), 32'h0);
    check("mrst_ready", 32'(ready_a), 32'h1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    beat(32'h00000001, 1'b1, 2'd0);
    check("post_rst_csum", csum_a, 32'h814141AB);
    check("post_rst_cnt", 32'(cnt_a), 32'h1);
    take();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
